// File: rtl/if_id_stage.sv
// Instruction-fetch front end: PC register, next-PC select with stalled-redirect
// buffering, IF/ID pipeline register and saturating stall/flush event counters.
module if_id_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 PCWrite,
    input  logic                 IF_ID_Write,
    input  logic                 IF_ID_flush,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_target,
    input  logic [31:0]          Instruction_in,
    output logic [31:0]          PC_out,
    output logic [31:0]          IF_ID_Instr,
    output logic [31:0]          IF_ID_PCPlus4,
    output logic                 IF_ID_Valid,
    output logic [4:0]           IF_ID_Rs,
    output logic [4:0]           IF_ID_Rt,
    output logic                 redirect_pending,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);

    logic [31:0]          r_pc, r_instr, r_pcp4, r_ptgt;
    logic                 r_valid, r_pend;
    logic [CNT_WIDTH-1:0] r_stall_cnt, r_flush_cnt;

    logic [31:0] w_tgt, w_pc_plus4, w_pc_next, w_ptgt_next;
    logic        w_pend_next;

    assign w_tgt      = {redirect_target[31:2], 2'b00};
    assign w_pc_plus4 = r_pc + 32'd4;

    // Next-PC select depends only on registered state and control inputs,
    // never on PC_out through imem, so no loop back to PC_out exists.
    always_comb begin
        w_pc_next   = r_pc;
        w_pend_next = r_pend;
        w_ptgt_next = r_ptgt;
        if (PCWrite) begin
            w_pend_next = 1'b0;
            if (redirect_valid)
                w_pc_next = w_tgt;
            else if (r_pend)
                w_pc_next = r_ptgt;
            else
                w_pc_next = w_pc_plus4;
        end else if (redirect_valid) begin
            w_ptgt_next = w_tgt;
            w_pend_next = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pc        <= RESET_PC;
            r_ptgt      <= 32'd0;
            r_pend      <= 1'b0;
            r_instr     <= 32'd0;
            r_pcp4      <= 32'd0;
            r_valid     <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_pc   <= w_pc_next;
            r_ptgt <= w_ptgt_next;
            r_pend <= w_pend_next;
            if (IF_ID_flush) begin
                r_instr <= 32'd0;
                r_pcp4  <= 32'd0;
                r_valid <= 1'b0;
            end else if (IF_ID_Write) begin
                r_instr <= Instruction_in;
                r_pcp4  <= w_pc_plus4;
                r_valid <= 1'b1;
            end
            if (!PCWrite && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (IF_ID_flush && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign PC_out           = r_pc;
    assign IF_ID_Instr      = r_instr;
    assign IF_ID_PCPlus4    = r_pcp4;
    assign IF_ID_Valid      = r_valid;
    assign IF_ID_Rs         = r_instr[25:21];
    assign IF_ID_Rt         = r_instr[20:16];
    assign redirect_pending = r_pend;
    assign stall_count      = r_stall_cnt;
    assign flush_count      = r_flush_cnt;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed-vector bench for if_id_stage; a second instance with CNT_WIDTH=2
// shares all inputs to exercise counter saturation.
module tb_if_id_stage;

    logic        Clk = 1'b0;
    logic        Reset, PCWrite, IF_ID_Write, IF_ID_flush, redirect_valid;
    logic [31:0] redirect_target, Instruction_in;

    logic [31:0] pc_a, instr_a, p4_a;
    logic        vld_a, pend_a;
    logic [4:0]  rs_a, rt_a;
    logic [15:0] stall_a, flush_a;

    logic [31:0] pc_b, instr_b, p4_b;
    logic        vld_b, pend_b;
    logic [4:0]  rs_b, rt_b;
    logic [1:0]  stall_b, flush_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    // Combinational imem model: distinct, field-rich word per address.
    function automatic logic [31:0] imem(input logic [31:0] pc);
        return {6'd8, pc[6:2], ~pc[6:2], pc[15:0]};
    endfunction

    assign Instruction_in = imem(pc_a);

    if_id_stage #(.RESET_PC(32'h0), .CNT_WIDTH(16)) u_dut (
        .Clk(Clk), .Reset(Reset), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
        .IF_ID_flush(IF_ID_flush), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .Instruction_in(Instruction_in),
        .PC_out(pc_a), .IF_ID_Instr(instr_a), .IF_ID_PCPlus4(p4_a),
        .IF_ID_Valid(vld_a), .IF_ID_Rs(rs_a), .IF_ID_Rt(rt_a),
        .redirect_pending(pend_a), .stall_count(stall_a), .flush_count(flush_a)
    );

    if_id_stage #(.RESET_PC(32'h0), .CNT_WIDTH(2)) u_dut_sat (
        .Clk(Clk), .Reset(Reset), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
        .IF_ID_flush(IF_ID_flush), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .Instruction_in(Instruction_in),
        .PC_out(pc_b), .IF_ID_Instr(instr_b), .IF_ID_PCPlus4(p4_b),
        .IF_ID_Valid(vld_b), .IF_ID_Rs(rs_b), .IF_ID_Rt(rt_b),
        .redirect_pending(pend_b), .stall_count(stall_b), .flush_count(flush_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic pcw, input logic ifw, input logic fl,
                         input logic rv, input logic [31:0] tgt);
        PCWrite = pcw; IF_ID_Write = ifw; IF_ID_flush = fl;
        redirect_valid = rv; redirect_target = tgt;
    endtask

    initial begin
        Reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(); step();
        chk("rst_pc",    pc_a,    32'h0);
        chk("rst_instr", instr_a, 32'h0);
        chk("rst_p4",    p4_a,    32'h0);
        chk("rst_vld",   {31'd0, vld_a},  32'd0);
        chk("rst_pend",  {31'd0, pend_a}, 32'd0);
        chk("rst_stall", {16'd0, stall_a}, 32'd0);
        chk("rst_flush", {16'd0, flush_a}, 32'd0);

        // Free run
        Reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        step();
        chk("run1_pc",    pc_a,    32'h4);
        chk("run1_p4",    p4_a,    32'h4);
        chk("run1_vld",   {31'd0, vld_a}, 32'd1);
        chk("run1_instr", instr_a, 32'h201F_0000);
        step();
        chk("run2_pc",    pc_a,    32'h8);
        chk("run2_p4",    p4_a,    32'h8);
        chk("run2_instr", instr_a, 32'h203E_0004);
        chk("run2_rs",    {27'd0, rs_a}, 32'd1);
        chk("run2_rt",    {27'd0, rt_a}, 32'h1E);

        // Stall three cycles at PC=8
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(); step(); step();
        chk("stall_pc",    pc_a,    32'h8);
        chk("stall_p4",    p4_a,    32'h8);
        chk("stall_instr", instr_a, 32'h203E_0004);
        chk("stall_cnt",   {16'd0, stall_a}, 32'd3);
        chk("stall_cnt_w2", {30'd0, stall_b}, 32'd3);

        // Flush wins over IF_ID_Write=0
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        step();
        chk("flush_pc",    pc_a,    32'hC);
        chk("flush_instr", instr_a, 32'h0);
        chk("flush_p4",    p4_a,    32'h0);
        chk("flush_vld",   {31'd0, vld_a}, 32'd0);
        chk("flush_cnt",   {16'd0, flush_a}, 32'd1);

        // Redirect with PCWrite=1, including misaligned target
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h40);
        step();
        chk("redir_pc",   pc_a, 32'h40);
        chk("redir_pend", {31'd0, pend_a}, 32'd0);
        chk("redir_p4",   p4_a, 32'h10);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h43);
        step();
        chk("redir_align_pc", pc_a, 32'h40);
        chk("redir_align_p4", p4_a, 32'h44);

        // Redirect arriving during a stall is held, then applied
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h80);
        step();
        chk("pend_set",    {31'd0, pend_a}, 32'd1);
        chk("pend_pchold", pc_a, 32'h40);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk("pend_keep",   {31'd0, pend_a}, 32'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        step();
        chk("pend_apply_pc", pc_a, 32'h80);
        chk("pend_clear",    {31'd0, pend_a}, 32'd0);
        chk("stall_cnt5",    {16'd0, stall_a}, 32'd5);
        chk("stall_sat_w2",  {30'd0, stall_b}, 32'd3);

        // Newer redirect overwrites older pending one
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h80);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h90);
        step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        step();
        chk("pend_over_pc",   pc_a, 32'h90);
        chk("pend_over_clr",  {31'd0, pend_a}, 32'd0);

        // Saturation sequence after a fresh reset
        Reset = 1'b1;
        step();
        chk("rst2_pc",    pc_a, 32'h0);
        chk("rst2_stall", {16'd0, stall_a}, 32'd0);
        chk("rst2_vld",   {31'd0, vld_a}, 32'd0);
        Reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(); chk("sat1", {30'd0, stall_b}, 32'd1);
        step(); chk("sat2", {30'd0, stall_b}, 32'd2);
        step(); chk("sat3", {30'd0, stall_b}, 32'd3);
        step(); chk("sat4", {30'd0, stall_b}, 32'd3);
        step(); chk("sat5", {30'd0, stall_b}, 32'd3);
        step(); chk("sat6", {30'd0, stall_b}, 32'd3);
        chk("nosat6", {16'd0, stall_a}, 32'd6);

        // Reset discards a pending redirect and clears counters
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h100);
        step();
        chk("pre_rst_pend", {31'd0, pend_a}, 32'd1);
        Reset = 1'b1;
        step();
        chk("rst3_pc",    pc_a, 32'h0);
        chk("rst3_pend",  {31'd0, pend_a}, 32'd0);
        chk("rst3_stall", {16'd0, stall_a}, 32'd0);
        chk("rst3_flush", {16'd0, flush_a}, 32'd0);
        chk("rst3_sat",   {30'd0, stall_b}, 32'd0);

        // PC+4 wraps modulo 2^32
        Reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
        step();
        chk("wrap_tgt", pc_a, 32'hFFFF_FFFC);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        step();
        chk("wrap_pc",  pc_a, 32'h0);
        chk("wrap_p4",  p4_a, 32'h0);
        chk("wrap_vld", {31'd0, vld_a}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
